// File: rtl/color_ctrl_pkg.sv
// ============================================================================
// Module      : color_ctrl_pkg
// Description : Shared types and constants for the color control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package color_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SWAP_H = 3'd2,
    ST_SWAP_V = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam int c_palette_count   = 4;
  localparam int c_palette_entries = 4;

  localparam logic [23:0] c_palette [c_palette_count][c_palette_entries] = '{
    '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h0000FF},
    '{24'h202020, 24'h00FF00, 24'hFF00FF, 24'hFFFF00},
    '{24'h101010, 24'h808080, 24'hC0C0C0, 24'hF0F0F0},
    '{24'h001F3F, 24'h0074D9, 24'h7FDBFF, 24'h39CCCC}
  };

  // Priority order of the frame-boundary actions: LOAD, then SWAP_H, then SWAP_V.
  function automatic state_t first_needed(input logic want_load,
                                          input logic want_h,
                                          input logic want_v);
    state_t s;
    if (want_load)   s = ST_LOAD;
    else if (want_h) s = ST_SWAP_H;
    else if (want_v) s = ST_SWAP_V;
    else             s = ST_IDLE;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/color_ctrl_btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchronizer, stability counter and rising-edge press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        // Press pulses together with the level change so the owner sees it one cycle later.
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/color_ctrl.sv
// ============================================================================
// Module      : color_ctrl
// Description : Frame-synchronous strobe sequencer and palette owner.
//               Define COLOR_CTRL_AUTO_EN to enable automatic palette rotation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_ctrl
  import color_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_FRAMES     = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_h,
  input  logic        btn_v,
  input  logic        btn_next,
  input  logic        sw_auto,
  input  logic        frame_start,
  output logic        color_valid,
  output logic        swap_h,
  output logic        swap_v,
  output logic [23:0] rgb0,
  output logic [23:0] rgb1,
  output logic [23:0] rgb2,
  output logic [23:0] rgb3,
  output logic        busy
);

  logic [2:0] w_btn_raw;
  logic [2:0] w_press;
  logic       w_press_h;
  logic       w_press_v;
  logic       w_press_next;
  logic       w_auto_adv;
  logic       w_advance;
  logic [1:0] w_idx_next;
  state_t     w_next_state;

  logic [1:0] r_idx;
  logic       r_pend_load;
  logic       r_pend_h;
  logic       r_pend_v;
  state_t     r_state;
  state_t     r_last;

  assign w_btn_raw = {btn_next, btn_v, btn_h};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(w_btn_raw[gi]),
      .press  (w_press[gi])
    );
  end

  assign w_press_h    = w_press[0];
  assign w_press_v    = w_press[1];
  assign w_press_next = w_press[2];

`ifdef COLOR_CTRL_AUTO_EN
  localparam int FC_W = ($clog2(AUTO_FRAMES + 1) > 7) ? $clog2(AUTO_FRAMES + 1) : 7;

  logic [FC_W-1:0] r_frame_cnt;

  assign w_auto_adv = sw_auto & frame_start & (r_frame_cnt == FC_W'(AUTO_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (rst || !sw_auto) begin
      r_frame_cnt <= '0;
    end else if (frame_start) begin
      r_frame_cnt <= w_auto_adv ? '0 : r_frame_cnt + 1'b1;
    end
  end
`else
  logic w_unused_auto;

  assign w_auto_adv    = 1'b0;
  assign w_unused_auto = sw_auto ^ (AUTO_FRAMES == 0);
`endif

  // A button advance and an auto advance in the same cycle collapse into one step.
  assign w_advance  = w_press_next | w_auto_adv;
  assign w_idx_next = r_idx + {1'b0, w_advance};

  // rgb follows the next index so it settles before any load strobe can reference it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 2'd0;
      rgb0  <= c_palette[0][0];
      rgb1  <= c_palette[0][1];
      rgb2  <= c_palette[0][2];
      rgb3  <= c_palette[0][3];
    end else begin
      r_idx <= w_idx_next;
      rgb0  <= c_palette[w_idx_next][0];
      rgb1  <= c_palette[w_idx_next][1];
      rgb2  <= c_palette[w_idx_next][2];
      rgb3  <= c_palette[w_idx_next][3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_load <= 1'b1;
      r_pend_h    <= 1'b0;
      r_pend_v    <= 1'b0;
    end else begin
      if (w_advance)               r_pend_load <= 1'b1;
      else if (r_state == ST_LOAD) r_pend_load <= 1'b0;

      // A press landing on its own issue cycle keeps the request alive for the next frame.
      if (w_press_h)                 r_pend_h <= (r_state == ST_SWAP_H) ? 1'b1 : ~r_pend_h;
      else if (r_state == ST_SWAP_H) r_pend_h <= 1'b0;

      if (w_press_v)                 r_pend_v <= (r_state == ST_SWAP_V) ? 1'b1 : ~r_pend_v;
      else if (r_state == ST_SWAP_V) r_pend_v <= 1'b0;
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        w_next_state = frame_start ? first_needed(r_pend_load, r_pend_h, r_pend_v) : ST_IDLE;
      end
      ST_LOAD, ST_SWAP_H, ST_SWAP_V: begin
        w_next_state = ST_GAP;
      end
      ST_GAP: begin
        // Only actions later in the order remain eligible within this sequence.
        case (r_last)
          ST_LOAD:   w_next_state = first_needed(1'b0, r_pend_h, r_pend_v);
          ST_SWAP_H: w_next_state = first_needed(1'b0, 1'b0, r_pend_v);
          default:   w_next_state = ST_IDLE;
        endcase
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= ST_IDLE;
      color_valid <= 1'b0;
      swap_h      <= 1'b0;
      swap_v      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      if (r_state == ST_LOAD || r_state == ST_SWAP_H || r_state == ST_SWAP_V) begin
        r_last <= r_state;
      end
      color_valid <= (w_next_state == ST_LOAD);
      swap_h      <= (w_next_state == ST_SWAP_H);
      swap_v      <= (w_next_state == ST_SWAP_V);
      busy        <= (w_next_state != ST_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_color_ctrl.sv
// ============================================================================
// Module      : tb_color_ctrl
// Description : Scoreboard bench for color_ctrl with directed button/frame vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_color_ctrl;

  localparam int DEB = 4;
  localparam int AF  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_h = 1'b0;
  logic        btn_v = 1'b0;
  logic        btn_next = 1'b0;
  logic        sw_auto = 1'b0;
  logic        frame_start = 1'b0;
  logic        color_valid;
  logic        swap_h;
  logic        swap_v;
  logic [23:0] rgb0;
  logic [23:0] rgb1;
  logic [23:0] rgb2;
  logic [23:0] rgb3;
  logic        busy;

  color_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_FRAMES    (AF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_h      (btn_h),
    .btn_v      (btn_v),
    .btn_next   (btn_next),
    .sw_auto    (sw_auto),
    .frame_start(frame_start),
    .color_valid(color_valid),
    .swap_h     (swap_h),
    .swap_v     (swap_v),
    .rgb0       (rgb0),
    .rgb1       (rgb1),
    .rgb2       (rgb2),
    .rgb3       (rgb3),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 load, 1 swap_h, 2 swap_v
    int          cycle;
    logic [95:0] rgb;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [95:0] pal[4];
  int          exp_idx = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rgb(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a strobe is presented.
  int          m_n;
  int          m_kind;
  exp_t        m_e;
  logic [95:0] m_prev_rgb = '0;

  always @(negedge clk) begin
    if (!rst) begin
      m_n = int'(color_valid) + int'(swap_h) + int'(swap_v);
      if (m_n > 1) check_int("one_strobe_at_a_time", m_n, 1);
      if (m_n == 1) begin
        m_kind = color_valid ? 0 : (swap_h ? 1 : 2);
        if (q.size() == 0) begin
          check_int("unexpected_strobe_kind", m_kind, -1);
        end else begin
          m_e = q.pop_front();
          check_int("strobe_kind", m_kind, m_e.kind);
          check_int("strobe_cycle", cyc, m_e.cycle);
          if (m_kind == 0) begin
            check_rgb("load_rgb", {rgb0, rgb1, rgb2, rgb3}, m_e.rgb);
            check_rgb("rgb_stable_before_load", m_prev_rgb, {rgb0, rgb1, rgb2, rgb3});
          end
        end
      end
    end
    m_prev_rgb = {rgb0, rgb1, rgb2, rgb3};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic val);
    case (which)
      0:       btn_h = val;
      1:       btn_v = val;
      default: btn_next = val;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick(10);
    set_btn(which, 1'b0);
    tick(10);
  endtask

  // Issues one frame_start, queues the expected strobes, and checks busy length.
  task automatic frame(input bit l, input bit h, input bit v);
    exp_t e;
    int   n;
    int   off;
    int   busy_cnt;
    n   = cyc;
    off = 1;
    if (l) begin e.kind = 0; e.cycle = n + off; e.rgb = pal[exp_idx]; q.push_back(e); off += 2; end
    if (h) begin e.kind = 1; e.cycle = n + off; e.rgb = '0;           q.push_back(e); off += 2; end
    if (v) begin e.kind = 2; e.cycle = n + off; e.rgb = '0;           q.push_back(e); off += 2; end
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    @(posedge clk);
    #1;
    check_int("busy_cycles", busy_cnt, off - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pal[0] = {24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h0000FF};
    pal[1] = {24'h202020, 24'h00FF00, 24'hFF00FF, 24'hFFFF00};
    pal[2] = {24'h101010, 24'h808080, 24'hC0C0C0, 24'hF0F0F0};
    pal[3] = {24'h001F3F, 24'h0074D9, 24'h7FDBFF, 24'h39CCCC};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_strobes", int'(color_valid) + int'(swap_h) + int'(swap_v), 0);
    check_rgb("reset_rgb", {rgb0, rgb1, rgb2, rgb3}, pal[0]);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);

    // First frame loads palette 0
    frame(1, 0, 0);

    // Single horizontal swap
    press(0);
    frame(0, 1, 0);

    // All three requests in order
    press(2);
    exp_idx = 1;
    check_rgb("rgb_after_next", {rgb0, rgb1, rgb2, rgb3}, pal[1]);
    press(0);
    press(1);
    frame(1, 1, 1);

    // Two presses of the same button cancel
    press(0);
    press(0);
    frame(0, 0, 0);

    // Index walks 1 -> 2 -> 3 -> 0 (wrap) and a single load fires
    for (int i = 0; i < 3; i++) begin
      press(2);
      exp_idx = (exp_idx + 1) % 4;
      check_rgb("rgb_idx_step", {rgb0, rgb1, rgb2, rgb3}, pal[exp_idx]);
    end
    frame(1, 0, 0);

    // Bounces of 1..3 cycles never register
    for (int w = 1; w <= 3; w++) begin
      btn_v = 1'b1;
      tick(w);
      btn_v = 1'b0;
      tick(4);
    end
    tick(10);
    frame(0, 0, 0);

    // btn_v press lands in the GAP after SWAP_V: issued on the following frame
    press(1);
    set_btn(1, 1'b1);
    tick(4);
    frame(0, 0, 1);
    set_btn(1, 1'b0);
    tick(12);
    frame(0, 0, 1);

    // btn_h press lands in the SWAP_H cycle itself: request repeats next frame
    press(0);
    set_btn(0, 1'b1);
    tick(5);
    frame(0, 1, 0);
    set_btn(0, 1'b0);
    tick(12);
    frame(0, 1, 0);

    // Reset coinciding with frame_start aborts: no strobe, palette back to 0
    press(2);
    exp_idx = (exp_idx + 1) % 4;
    rst = 1'b1;
    frame_start = 1'b1;
    tick(1);
    rst = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    check_int("reset_abort_busy", int'(busy), 0);
    check_int("reset_abort_strobes", int'(color_valid) + int'(swap_h) + int'(swap_v), 0);
    check_rgb("reset_abort_rgb", {rgb0, rgb1, rgb2, rgb3}, pal[0]);
    exp_idx = 0;
    tick(3);
    frame(1, 0, 0);

`ifdef COLOR_CTRL_AUTO_EN
    // Three frames with sw_auto advance the palette; the load fires on the fourth
    sw_auto = 1'b1;
    frame(0, 0, 0);
    frame(0, 0, 0);
    frame(0, 0, 0);
    exp_idx = (exp_idx + 1) % 4;
    check_rgb("auto_rgb_advance", {rgb0, rgb1, rgb2, rgb3}, pal[exp_idx]);
    frame(1, 0, 0);
    // Dropping sw_auto clears the count: no advance after 2 + 1 frames
    sw_auto = 1'b0;
    tick(2);
    sw_auto = 1'b1;
    frame(0, 0, 0);
    frame(0, 0, 0);
    sw_auto = 1'b0;
    frame(0, 0, 0);
    check_rgb("auto_no_advance_rgb", {rgb0, rgb1, rgb2, rgb3}, pal[exp_idx]);
`else
    // Without the auto feature sw_auto has no effect
    sw_auto = 1'b1;
    repeat (4) frame(0, 0, 0);
    sw_auto = 1'b0;
    check_rgb("auto_disabled_rgb", {rgb0, rgb1, rgb2, rgb3}, pal[exp_idx]);
`endif

    tick(5);
    check_int("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/color_ctrl.md
# color_ctrl

Control sequencer for the color processor. It debounces the swap-horizontal, swap-vertical and next-palette pushbuttons, and holds each request until the next frame boundary. At that boundary it issues the requests to the color processor as single-cycle strobes, one at a time with a gap cycle between them, because simultaneous `color_valid`, `swap_h` and `swap_v` in the same cycle override one another. It also owns the palette index and drives `rgb0..rgb3` from the palette table.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable cycles before a debounced level changes.
- `AUTO_FRAMES`, default 60: frames between automatic palette advances.
- `clk`, input, 1: system clock. The block uses one clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `btn_h`, `btn_v`, `btn_next`, input, 1 each: raw asynchronous pushbuttons. Each passes through a 2-flop synchronizer first.
- `sw_auto`, input, 1: enables automatic palette rotation.
- `frame_start`, input, 1: one-cycle pulse from VGA timing at the start of vertical blanking.
- `color_valid`, output, 1: one-cycle load strobe.
- `swap_h`, `swap_v`, output, 1 each: one-cycle swap strobes.
- `rgb0`, `rgb1`, `rgb2`, `rgb3`, output, 24 each: the current palette entries. Registered.
- `busy`, output, 1: high while a frame-boundary sequence is running.

## Operation
- **Press detection:** a press is the rising edge of a debounced level. The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- **`btn_next` press:**
  - Palette index `idx` (2 bits) increments; 3 wraps to 0.
  - `rgb*` update on the next cycle.
  - `pend_load` is set.
- **`btn_h` / `btn_v` press:** toggles `pend_h` / `pend_v`. Two presses of the same button within one frame cancel out.
- **Press in the cycle its action is issued:** the pending flag is left set, or re-set, so the action repeats at the next frame.
- **State machine:** IDLE, LOAD, SWAP_H, SWAP_V, GAP.
  - IDLE: on `frame_start` with any pending flag set, go to the first needed action. Order is LOAD, then SWAP_H, then SWAP_V. Unneeded actions are skipped.
  - Each action state asserts its strobe for exactly 1 cycle, clears its flag, and moves to GAP.
  - GAP lasts 1 cycle, then goes to the next needed action or back to IDLE.
  - `busy` = (state != IDLE).
- **While busy:**
  - `frame_start` is ignored.
  - New presses are recorded but not issued until a later frame, unless a flag is set before its action state is reached in the current sequence.
- **Reset:**
  - State is IDLE, `idx`=0, `rgb*` = palette 0, all strobes 0, `busy`=0.
  - `pend_h` = `pend_v` = 0; `pend_load` = 1, so palette 0 is loaded at the first frame.
  - Debouncers and the frame counter reset to 0.
  - A reset mid-sequence aborts the sequence; no strobe is asserted in the reset cycle.

## Timing
- Press latency: from raw edge to `pend_*` set is 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles.
- From `frame_start` (cycle N):
  - First strobe at N+1.
  - Worst-case sequence: LOAD@N+1, GAP, SWAP_H@N+3, GAP, SWAP_V@N+5, GAP, IDLE@N+7.
- At most one output strobe is high in any cycle.
- `rgb*` are stable for at least 1 cycle before and during `color_valid`.

## Configuration
- `COLOR_CTRL_AUTO_EN` defined:
  - A 7-bit-minimum frame counter counts `frame_start` pulses while `sw_auto`=1 and clears when `sw_auto`=0.
  - When it reaches `AUTO_FRAMES` it resets to 0, increments `idx` and sets `pend_load`.
  - The advance takes effect at the next `frame_start`.
  - An auto advance and a `btn_next` press in the same cycle increment `idx` only once.
- `COLOR_CTRL_AUTO_EN` undefined: no frame counter; `sw_auto` is ignored.

## Structure
- Shared package `color_ctrl_pkg`:
  - State encoding enum.
  - 4x4 palette table of 24-bit constants.
  - Palette-count constant.
- Sub-module `btn_debounce`: synchronizer, counter and rising-edge press pulse, parameterised by `DEBOUNCE_CYCLES`. Instantiated 3 times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `AUTO_FRAMES`=3.
- Reset release then `frame_start` → `color_valid` for 1 cycle at N+1 with `rgb0` = palette[0][0]; `busy` for 2 cycles; no swaps.
- `btn_h` held 10 cycles, then `frame_start` → `swap_h` pulse at N+1 only; `color_valid` and `swap_v` stay 0.
- `btn_next` + `btn_h` + `btn_v` pressed, then `frame_start` → `color_valid`@N+1, `swap_h`@N+3, `swap_v`@N+5, `busy` low at N+7; `idx`=1.
- `btn_h` pressed twice before a frame → no strobe at `frame_start`. `btn_next` pressed 4 times → `idx` wraps to 0 and `color_valid` fires once.
- Bounce `btn_v` with 1–3-cycle pulses → no press. Then a press landing mid-sequence during GAP after SWAP_V → `swap_v` on the following frame.
- With `COLOR_CTRL_AUTO_EN`, `sw_auto`=1, 3 frames → `idx` increments and `color_valid` fires at the 4th `frame_start`. Dropping `sw_auto` after 2 frames → no advance.
